// File: rtl/surf4_wb_pkg.sv
// Shared definitions for the SURF4 Wishbone register slaves.
// Register indices, default ident words, FSM states, lane merge.
package surf4_wb_pkg;

    localparam logic [3:0] IDX_IDENT    = 4'd0;
    localparam logic [3:0] IDX_VERSION  = 4'd1;
    localparam logic [3:0] IDX_CONTROL  = 4'd2;
    localparam logic [3:0] IDX_SCRATCH  = 4'd3;
    localparam logic [3:0] IDX_CLKCNT   = 4'd4;
    localparam logic [3:0] IDX_LED      = 4'd5;
    localparam logic [3:0] IDX_RESETREQ = 4'd6;

    localparam logic [31:0] IDENT_DEFAULT   = 32'h53555246;
    localparam logic [31:0] VERSION_DEFAULT = 32'h00000001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } wb_state_t;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/s4_id_ctrl_if.sv
// Wishbone B3 classic bus bundle for the SURF4 ident/control slave.
// master drives the request, slave drives the response.
interface s4_id_ctrl_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [19:0] adr;
    logic [31:0] dat_w;
    logic [3:0]  sel;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_w, sel,
        input  dat_r, ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel,
        output dat_r, ack, err, rty
    );
endinterface

// File: rtl/s4_pulse_stretch.sv
// Retriggerable pulse stretcher: a trig starts (or restarts)
// a pulse LEN cycles long beginning the cycle after trig.
module s4_pulse_stretch #(
    parameter int LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic trig,
    output logic pulse
);
    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt_q;

    // Load the full length on trig, otherwise count down to zero.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (trig) begin
            cnt_q <= CW'(LEN);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign pulse = (cnt_q != '0);

endmodule

// File: rtl/s4_id_ctrl.sv
// SURF4 ident/control Wishbone slave: ident, version, control,
// scratch, LED, soft reset; CLKCNT counter with S4_ID_CTRL_CLKCNT_EN.
import surf4_wb_pkg::*;

module s4_id_ctrl #(
    parameter logic [31:0] IDENT   = IDENT_DEFAULT,
    parameter logic [31:0] VERSION = VERSION_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [19:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        rty_o,
    output logic [31:0] ctrl_o,
    output logic [3:0]  led_o,
    output logic        rst_req_o
);

    wb_state_t   state_q, state_d;
    logic        req;
    logic        wr;
    logic        bad;
    logic [3:0]  idx;
    logic [31:0] rdata;
    logic [31:0] ctrl_q;
    logic [31:0] scratch_q;
    logic [3:0]  led_q;
    logic [31:0] clkcnt;
    logic        rst_trig;
    logic        unused_adr;

    assign idx        = adr_i[5:2];
    assign unused_adr = ^{adr_i[19:6], adr_i[1:0]};
    assign req        = (state_q == ST_IDLE) && cyc_i && stb_i;
    assign wr         = req && we_i && !bad;
    assign rty_o      = 1'b0;
    assign ctrl_o     = ctrl_q;
    assign led_o      = led_q;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state: one response cycle per accepted request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cyc_i && stb_i) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Address decode: read mux and error classification.
    always_comb begin
        rdata = '0;
        bad   = 1'b0;
        case (idx)
            IDX_IDENT:    begin rdata = IDENT;   bad = we_i; end
            IDX_VERSION:  begin rdata = VERSION; bad = we_i; end
            IDX_CONTROL:  rdata = ctrl_q;
            IDX_SCRATCH:  rdata = scratch_q;
            IDX_CLKCNT:   begin rdata = clkcnt;  bad = we_i; end
            IDX_LED:      rdata = {28'h0, led_q};
            IDX_RESETREQ: rdata = '0;
            default:      bad = 1'b1;
        endcase
    end

    // Response registers: valid only in the cycle after acceptance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else if (req) begin
            ack_o <= !bad;
            err_o <= bad;
            dat_o <= (bad || we_i) ? 32'h0 : rdata;
        end else begin
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end
    end

    // Writable registers commit at the accepting edge, per byte lane.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ctrl_q    <= '0;
            scratch_q <= '0;
            led_q     <= '0;
        end else if (wr) begin
            if (idx == IDX_CONTROL)
                ctrl_q <= byte_merge(ctrl_q, dat_i, sel_i);
            if (idx == IDX_SCRATCH)
                scratch_q <= byte_merge(scratch_q, dat_i, sel_i);
            if (idx == IDX_LED && sel_i[0])
                led_q <= dat_i[3:0];
        end
    end

`ifdef S4_ID_CTRL_CLKCNT_EN
    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) clkcnt <= '0;
        else          clkcnt <= clkcnt + 32'd1;
    end
`else
    assign clkcnt = '0;
`endif

    assign rst_trig = wr && (idx == IDX_RESETREQ)
                      && sel_i[0] && dat_i[0];

    s4_pulse_stretch #(
        .LEN (4)
    ) u_rst_pulse (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .trig    (rst_trig),
        .pulse   (rst_req_o)
    );

endmodule

// File: tb/tb_s4_id_ctrl.sv
// Directed self-checking bench for s4_id_ctrl.
// Expectations for CLKCNT follow S4_ID_CTRL_CLKCNT_EN.
module tb_s4_id_ctrl;

    logic clk_i = 1'b0;
    logic rst_n_i;

    s4_id_ctrl_if bus ();

    logic [31:0] ctrl_o;
    logic [3:0]  led_o;
    logic        rst_req_o;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    s4_id_ctrl dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .cyc_i     (bus.cyc),
        .stb_i     (bus.stb),
        .we_i      (bus.we),
        .adr_i     (bus.adr),
        .dat_i     (bus.dat_w),
        .sel_i     (bus.sel),
        .dat_o     (bus.dat_r),
        .ack_o     (bus.ack),
        .err_o     (bus.err),
        .rty_o     (bus.rty),
        .ctrl_o    (ctrl_o),
        .led_o     (led_o),
        .rst_req_o (rst_req_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [19:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
        bus.cyc   = 1'b1;
        bus.stb   = 1'b1;
        bus.we    = we;
        bus.adr   = adr;
        bus.dat_w = dat;
        bus.sel   = sel;
    endtask

    task automatic idle_bus();
        bus.cyc = 1'b0;
        bus.stb = 1'b0;
        bus.we  = 1'b0;
    endtask

    // One transaction: present at negedge, sample #1 after accept edge.
    task automatic bus_op(input logic we, input logic [19:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel,
                          output logic a, output logic e,
                          output logic [31:0] d);
        @(negedge clk_i);
        drive(we, adr, dat, sel);
        @(posedge clk_i);
        #1;
        a = bus.ack;
        e = bus.err;
        d = bus.dat_r;
        idle_bus();
        @(posedge clk_i);
    endtask

    logic        a, e;
    logic [31:0] d, c1, c2;
    int          n;
    logic [5:0]  pat;

    initial begin
        rst_n_i   = 1'b0;
        bus.cyc   = 1'b0;
        bus.stb   = 1'b0;
        bus.we    = 1'b0;
        bus.adr   = '0;
        bus.dat_w = '0;
        bus.sel   = '0;
        #12;
        check("rst_ack", {31'h0, bus.ack}, 32'h0);
        check("rst_err", {31'h0, bus.err}, 32'h0);
        check("rst_dat", bus.dat_r, 32'h0);
        check("rst_ctrl", ctrl_o, 32'h0);
        check("rst_led", {28'h0, led_o}, 32'h0);
        check("rst_req", {31'h0, rst_req_o}, 32'h0);
        check("rty", {31'h0, bus.rty}, 32'h0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Ident and version reads.
        bus_op(1'b0, 20'h00000, 32'h0, 4'hF, a, e, d);
        check("id_ack", {31'h0, a}, 32'h1);
        check("id_dat", d, 32'h53555246);
        bus_op(1'b0, 20'h00004, 32'h0, 4'hF, a, e, d);
        check("ver_ack", {31'h0, a}, 32'h1);
        check("ver_dat", d, 32'h00000001);

        // Scratch with byte lanes.
        bus_op(1'b1, 20'h0000C, 32'hDEADBEEF, 4'hF, a, e, d);
        check("scr_w1_ack", {31'h0, a}, 32'h1);
        bus_op(1'b1, 20'h0000C, 32'h00000055, 4'h1, a, e, d);
        check("scr_w2_ack", {31'h0, a}, 32'h1);
        bus_op(1'b0, 20'h0000C, 32'h0, 4'hF, a, e, d);
        check("scr_rd", d, 32'hDEADBE55);

        // Unmapped read and read-only write.
        bus_op(1'b0, 20'h0001C, 32'h0, 4'hF, a, e, d);
        check("unmap_err", {31'h0, e}, 32'h1);
        check("unmap_ack", {31'h0, a}, 32'h0);
        check("unmap_dat", d, 32'h0);
        bus_op(1'b1, 20'h00000, 32'h0, 4'hF, a, e, d);
        check("ro_err", {31'h0, e}, 32'h1);
        check("ro_ack", {31'h0, a}, 32'h0);
        bus_op(1'b0, 20'h00000, 32'h0, 4'hF, a, e, d);
        check("id_keep", d, 32'h53555246);

        // Control lanes 0 and 2 only.
        bus_op(1'b1, 20'h00008, 32'hA5A50001, 4'b0101, a, e, d);
        check("ctrl_o", ctrl_o, 32'h00A50001);

        // LED with upper address bits set, unused bits read 0.
        bus_op(1'b1, 20'hFFF14, 32'h000000FF, 4'hF, a, e, d);
        check("led_o", {28'h0, led_o}, 32'hF);
        bus_op(1'b0, 20'h00017, 32'h0, 4'hF, a, e, d);
        check("led_rd", d, 32'h0000000F);

        // RESETREQ reads as zero.
        bus_op(1'b0, 20'h00018, 32'h0, 4'hF, a, e, d);
        check("rreq_rd_ack", {31'h0, a}, 32'h1);
        check("rreq_rd", d, 32'h0);

        // Single soft-reset pulse: 4 cycles.
        n = 0;
        @(negedge clk_i);
        drive(1'b1, 20'h00018, 32'h1, 4'h1);
        @(posedge clk_i);
        #1;
        n += int'(rst_req_o);
        idle_bus();
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_i);
            #1;
            n += int'(rst_req_o);
        end
        check("pulse_len", n, 32'd4);

        // Retrigger during the 2nd high cycle: 6 cycles total.
        n = 0;
        @(negedge clk_i);
        drive(1'b1, 20'h00018, 32'h1, 4'h1);
        @(posedge clk_i);
        #1;
        n += int'(rst_req_o);
        idle_bus();
        @(posedge clk_i);
        #1;
        n += int'(rst_req_o);
        @(negedge clk_i);
        drive(1'b1, 20'h00018, 32'h1, 4'h1);
        @(posedge clk_i);
        #1;
        n += int'(rst_req_o);
        check("retrig_ack", {31'h0, bus.ack}, 32'h1);
        idle_bus();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i);
            #1;
            n += int'(rst_req_o);
        end
        check("pulse_retrig", n, 32'd6);

        // CLKCNT: accept edges exactly 10 cycles apart.
        bus_op(1'b0, 20'h00010, 32'h0, 4'hF, a, e, d);
        c1 = d;
        check("cnt1_ack", {31'h0, a}, 32'h1);
        repeat (8) @(posedge clk_i);
        bus_op(1'b0, 20'h00010, 32'h0, 4'hF, a, e, d);
        c2 = d;
`ifdef S4_ID_CTRL_CLKCNT_EN
        check("cnt_diff", c2 - c1, 32'd10);
`else
        check("cnt1_zero", c1, 32'h0);
        check("cnt2_zero", c2, 32'h0);
`endif
        bus_op(1'b1, 20'h00010, 32'h5, 4'hF, a, e, d);
        check("cnt_wr_err", {31'h0, e}, 32'h1);

        // Strobe held: one response every 2 cycles.
        pat = '0;
        @(negedge clk_i);
        drive(1'b0, 20'h00000, 32'h0, 4'hF);
        for (int i = 5; i >= 0; i--) begin
            @(posedge clk_i);
            #1;
            pat[i] = bus.ack;
        end
        idle_bus();
        @(posedge clk_i);
        check("hold_pat", {26'h0, pat}, 32'h0000002A);

        // Reset in the response cycle of a control write.
        @(negedge clk_i);
        drive(1'b1, 20'h00008, 32'h1, 4'hF);
        @(posedge clk_i);
        #1;
        check("pre_rst_ack", {31'h0, bus.ack}, 32'h1);
        check("pre_rst_ctrl", ctrl_o, 32'h1);
        #1;
        rst_n_i = 1'b0;
        #1;
        check("async_ack", {31'h0, bus.ack}, 32'h0);
        check("async_ctrl", ctrl_o, 32'h0);
        idle_bus();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("post_rst_ack", {31'h0, bus.ack}, 32'h0);
        check("post_rst_err", {31'h0, bus.err}, 32'h0);
        bus_op(1'b0, 20'h00008, 32'h0, 4'hF, a, e, d);
        check("post_rd_ack", {31'h0, a}, 32'h1);
        check("post_rd_ctrl", d, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/s4_id_ctrl.md
S4_ID_CTRL -- requirements
Module: s4_id_ctrl

Interface
REQ-001 SHALL have parameter IDENT, default 32'h53555246 ("SURF"), read-only board ident word.
REQ-002 SHALL have parameter VERSION, default 32'h00000001, read-only firmware version word.
REQ-003 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cyc_i, stb_i, we_i  input  1 each  Wishbone B3 classic slave controls.
REQ-006 SHALL have ports adr_i  input  20 (byte address), dat_i  input  32, sel_i  input  4.
REQ-007 SHALL have ports dat_o  output  32, ack_o, err_o, rty_o  output  1 each  Wishbone slave responses.
REQ-008 SHALL have ports ctrl_o  output  32  CONTROL register; led_o  output  4  LED register; rst_req_o  output  1  soft-reset pulse.

Function
REQ-009 SHALL decode word index adr_i[5:2]: 0 IDENT (RO), 1 VERSION (RO), 2 CONTROL (RW), 3 SCRATCH (RW), 4 CLKCNT (RO), 5 LED (RW, bits[3:0]), 6 RESETREQ (WO); indices 7-15 unmapped; adr_i[19:6] and adr_i[1:0] ignored.
REQ-010 SHALL use a two-state FSM: IDLE, RESP; IDLE->RESP when cyc_i&stb_i sampled high; RESP->IDLE unconditionally after one cycle.
REQ-011 SHALL assert exactly one of ack_o/err_o for exactly one cycle (the RESP cycle), one clock after the request is sampled in IDLE.
REQ-012 SHALL return to IDLE for at least one cycle between responses: strobe held high continuously yields one response every 2 cycles.
REQ-013 SHALL assert err_o (not ack_o) for unmapped indices and for writes to IDENT, VERSION or CLKCNT; such writes SHALL change no state.
REQ-014 SHALL tie rty_o to 0.
REQ-015 SHALL commit writes on the clock edge where the request is sampled in IDLE, per byte lane: lane n updated only if sel_i[n]=1.
REQ-016 SHALL register read data into dat_o at the sampling edge; dat_o valid during RESP; dat_o=0 in IDLE and on err_o responses.
REQ-017 SHALL return 0 on read of RESETREQ and on unused bits of LED.
REQ-018 SHALL complete a response even if cyc_i drops during RESP; a write already committed is not undone.
REQ-019 SHALL increment CLKCNT by 1 every clk_i cycle, wrapping 32'hFFFFFFFF->0; a read returns the value at the sampling edge.
REQ-020 SHALL, on a write to RESETREQ with sel_i[0]=1 and dat_i[0]=1, drive rst_req_o high for exactly 4 cycles starting the cycle after the sampling edge.
REQ-021 SHALL restart the 4-cycle count if a new RESETREQ write arrives while rst_req_o is high.
REQ-022 SHALL drive ctrl_o and led_o directly from the CONTROL and LED registers (no extra latency).

Reset
REQ-023 SHALL, while rst_n_i=0, asynchronously force: FSM=IDLE, ack_o=0, err_o=0, dat_o=0, CONTROL=0, SCRATCH=0, LED=0, CLKCNT=0, rst_req_o=0, pulse counter=0.
REQ-024 SHALL abandon any in-flight request on reset assertion; no response issued for it after release.
REQ-025 SHALL release synchronously in effect: first request accepted at the first rising edge with rst_n_i=1.

Configuration
REQ-026 SHALL include the CLKCNT counter only when macro S4_ID_CTRL_CLKCNT_EN is defined.
REQ-027 SHALL, without S4_ID_CTRL_CLKCNT_EN, keep index 4 mapped: reads return 32'h0 with ack_o, writes return err_o, and no counter flops exist.

Structure
REQ-028 SHALL take register index constants (IDX_IDENT..IDX_RESETREQ), default IDENT/VERSION values and FSM state encodings from the shared package surf4_wb_pkg.
REQ-029 SHALL implement the rst_req_o stretcher as sub-module s4_pulse_stretch (parameter LEN=4, input trig, output pulse, retriggerable).

Verification
REQ-030 Read adr 0x00 then 0x04 -> ack_o one cycle after each strobe, dat_o=32'h53555246 then 32'h00000001.
REQ-031 Write SCRATCH 32'hDEADBEEF sel=4'b1111, then write 32'h00000055 sel=4'b0001, read back -> 32'hDEADBE55, each with ack_o.
REQ-032 Read adr 0x1C; write 32'h0 to adr 0x00 -> err_o each, ack_o=0, IDENT still reads 32'h53555246.
REQ-033 Write RESETREQ dat=1 -> rst_req_o high 4 cycles; rewrite at 2nd high cycle -> total high 6 cycles.
REQ-034 Two reads of CLKCNT with strobes exactly 10 cycles apart -> difference 10; with macro undefined -> both 0.
REQ-035 Assert rst_n_i during RESP of a CONTROL write 32'h1 -> ack_o drops immediately, ctrl_o=0, FSM IDLE after release.
